jelly_fifo_burst_arbiter: RTL and testbench



---
 rtl/jelly_round_robin_select.sv | 36 +++
 rtl/jelly_fifo_burst_arbiter.sv | 164 ++++++++++++++++
 tb/tb_jelly_fifo_burst_arbiter.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jelly_round_robin_select.sv
// jelly_round_robin_select
//   Combinational round-robin picker. Starting just after the last granted
//   index, scans the request mask in ascending order with wrap-around and
//   returns the first requester found.
// Ports:
//   req    in  NUM       request mask, one bit per channel
//   last   in  ID_WIDTH  index granted most recently (lowest priority now)
//   found  out 1         at least one request is set
//   grant  out ID_WIDTH  selected channel (0 when found is low)
module jelly_round_robin_select #(
  parameter int NUM      = 4,
  parameter int ID_WIDTH = 2
) (
  input  logic [NUM-1:0]      req,
  input  logic [ID_WIDTH-1:0] last,
  output logic                found,
  output logic [ID_WIDTH-1:0] grant
);

  // Walk the offsets from farthest to nearest so that the nearest requester
  // (smallest offset after 'last') is the one left standing.
  always_comb begin : scan
    int idx;
    found = 1'b0;
    grant = '0;
    idx   = 0;
    for (int k = NUM; k >= 1; k--) begin
      idx = (int'(last) + k) % NUM;
      if (req[idx]) begin
        found = 1'b1;
        grant = ID_WIDTH'(idx);
      end
    end
  end

endmodule

// File: rtl/jelly_fifo_burst_arbiter.sv
// jelly_fifo_burst_arbiter
//   Round-robin burst scheduler sharing one downstream stream between NUM
//   first-word-fall-through FIFO read ports. A channel wins arbitration only
//   when a whole burst is buffered (or it asks for a flush); the grant then
//   lasts for exactly the number of beats latched at grant time.
// Ports:
//   reset            in   async active-high reset
//   clk              in   clock
//   param_burst_len  in   beats per burst (0 behaves as 1)
//   s_flush          in   per-channel permission to send a short burst
//   s_count          in   per-channel buffered word count
//   s_data/s_valid   in   per-channel FIFO head data and valid
//   s_ready          out  per-channel read strobe (only granted channel)
//   m_data/m_id      out  registered beat data and source channel
//   m_last           out  final beat of a burst
//   m_valid/m_ready  out/in downstream handshake
//   busy             out  high while a burst is granted
module jelly_fifo_burst_arbiter #(
  parameter int NUM         = 4,
  parameter int ID_WIDTH    = 2,
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = 11,
  parameter int LEN_WIDTH   = 8
) (
  input  logic                        reset,
  input  logic                        clk,
  input  logic [LEN_WIDTH-1:0]        param_burst_len,
  input  logic [NUM-1:0]              s_flush,
  input  logic [NUM*COUNT_WIDTH-1:0]  s_count,
  input  logic [NUM*DATA_WIDTH-1:0]   s_data,
  input  logic [NUM-1:0]              s_valid,
  output logic [NUM-1:0]              s_ready,
  output logic [DATA_WIDTH-1:0]       m_data,
  output logic [ID_WIDTH-1:0]         m_id,
  output logic                        m_last,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic                        busy
);

  // Comparison width wide enough for both the counts and the burst length.
  localparam int CMP_WIDTH = (COUNT_WIDTH > LEN_WIDTH) ? COUNT_WIDTH : LEN_WIDTH;
  // Beat counter has one extra bit so the largest length fits comfortably.
  localparam int REM_WIDTH = LEN_WIDTH + 1;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t                 state_reg;
  state_t                 state_next;
  logic [ID_WIDTH-1:0]    sel_reg;
  logic [REM_WIDTH-1:0]   remaining_reg;
  logic [ID_WIDTH-1:0]    last_grant_reg;

  logic [COUNT_WIDTH-1:0] ch_count [NUM];
  logic [DATA_WIDTH-1:0]  ch_data  [NUM];
  logic [NUM-1:0]         elig;
  logic [CMP_WIDTH-1:0]   len_cmp;
  logic                   rr_found;
  logic [ID_WIDTH-1:0]    rr_grant;
  logic [CMP_WIDTH-1:0]   grant_count;
  logic [CMP_WIDTH-1:0]   beats_cmp;
  logic                   out_ready;
  logic                   take;
  logic                   last_beat;

  // A zero length would never finish a burst, so it is promoted to one.
  assign len_cmp = (param_burst_len == '0) ? CMP_WIDTH'(1) : CMP_WIDTH'(param_burst_len);

  generate
    for (genvar gi = 0; gi < NUM; gi++) begin : g_ch
      assign ch_count[gi] = s_count[gi*COUNT_WIDTH +: COUNT_WIDTH];
      assign ch_data[gi]  = s_data[gi*DATA_WIDTH +: DATA_WIDTH];
      // Full burst buffered, or a flush with anything at all buffered.
      assign elig[gi] = s_valid[gi] &
                        ((CMP_WIDTH'(ch_count[gi]) >= len_cmp) |
                         (s_flush[gi] & (ch_count[gi] != '0)));
    end
  endgenerate

  jelly_round_robin_select #(
    .NUM      (NUM),
    .ID_WIDTH (ID_WIDTH)
  ) u_select (
    .req   (elig),
    .last  (last_grant_reg),
    .found (rr_found),
    .grant (rr_grant)
  );

  // Burst size is the shorter of what is buffered and the configured length;
  // a flushed channel therefore sends only what it has.
  assign grant_count = CMP_WIDTH'(ch_count[rr_grant]);
  assign beats_cmp   = (grant_count < len_cmp) ? grant_count : len_cmp;

  // The output register can accept a beat when empty or draining this cycle.
  assign out_ready = ~m_valid | m_ready;
  assign take      = (state_reg == BURST) & s_valid[sel_reg] & out_ready;
  assign last_beat = (remaining_reg == REM_WIDTH'(1));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (rr_found) state_next = BURST;
      BURST:   if (take && last_beat) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State outputs
  always_comb begin
    s_ready = '0;
    busy    = 1'b0;
    if (state_reg == BURST) begin
      busy             = 1'b1;
      s_ready[sel_reg] = out_ready;
    end
  end

  // Grant bookkeeping and output register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_reg        <= '0;
      remaining_reg  <= '0;
      last_grant_reg <= ID_WIDTH'(NUM - 1);
      m_data         <= '0;
      m_id           <= '0;
      m_last         <= 1'b0;
      m_valid        <= 1'b0;
    end else begin
      // Length and count are sampled only here; later changes are ignored.
      if (state_reg == IDLE && rr_found) begin
        sel_reg       <= rr_grant;
        remaining_reg <= REM_WIDTH'(beats_cmp);
      end

      if (take) begin
        remaining_reg <= remaining_reg - REM_WIDTH'(1);
        if (last_beat) begin
          last_grant_reg <= sel_reg;
        end
        m_data  <= ch_data[sel_reg];
        m_id    <= sel_reg;
        m_last  <= last_beat;
        m_valid <= 1'b1;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_jelly_fifo_burst_arbiter.sv
module tb_jelly_fifo_burst_arbiter;

  localparam int NUM = 4;
  localparam int IW  = 2;
  localparam int DW  = 8;
  localparam int CW  = 11;
  localparam int LW  = 8;

  logic               reset;
  logic               clk;
  logic [LW-1:0]      param_burst_len;
  logic [NUM-1:0]     s_flush;
  logic [NUM*CW-1:0]  s_count;
  logic [NUM*DW-1:0]  s_data;
  logic [NUM-1:0]     s_valid;
  logic [NUM-1:0]     s_ready;
  logic [DW-1:0]      m_data;
  logic [IW-1:0]      m_id;
  logic               m_last;
  logic               m_valid;
  logic               m_ready;
  logic               busy;

  jelly_fifo_burst_arbiter #(
    .NUM(NUM), .ID_WIDTH(IW), .DATA_WIDTH(DW), .COUNT_WIDTH(CW), .LEN_WIDTH(LW)
  ) dut (
    .reset(reset), .clk(clk), .param_burst_len(param_burst_len),
    .s_flush(s_flush), .s_count(s_count), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .m_data(m_data), .m_id(m_id), .m_last(m_last),
    .m_valid(m_valid), .m_ready(m_ready), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [IW-1:0] id;
    logic          last;
  } beat_t;

  // Bench-side FIFOs and scenario knobs
  logic [DW-1:0]  chq [NUM][$];
  logic [NUM-1:0] valid_en;
  logic [NUM-1:0] flush;
  logic [LW-1:0]  plen;

  // Reference model: who holds the grant, beats left, pointer, output occupancy
  bit    mdl_busy;
  int    mdl_sel;
  int    mdl_rem;
  int    mdl_ptr;
  bit    mdl_ov;
  beat_t expq[$];
  int    beats_out;

  int checks;
  int failures;

  function automatic int eff_len();
    return (plen == 0) ? 1 : int'(plen);
  endfunction

  function automatic bit eligible(int c, int len);
    int n;
    n = chq[c].size();
    return valid_en[c] && (n > 0) && ((n >= len) || flush[c]);
  endfunction

  task automatic drive_inputs();
    for (int i = 0; i < NUM; i++) begin
      s_count[i*CW +: CW] = CW'(chq[i].size());
      s_data[i*DW +: DW]  = (chq[i].size() > 0) ? chq[i][0] : '0;
      s_valid[i]          = valid_en[i] && (chq[i].size() > 0);
    end
    s_flush         = flush;
    param_burst_len = plen;
  endtask

  task automatic model_reset();
    mdl_busy = 0;
    mdl_sel  = 0;
    mdl_rem  = 0;
    mdl_ptr  = NUM - 1;
    mdl_ov   = 0;
    expq.delete();
  endtask

  // One clock: compare at negedge, decide the model's next step, commit after posedge.
  task automatic cycle();
    logic [NUM-1:0] exp_ready;
    bit    hs;
    bit    ov_n;
    beat_t b;
    drive_inputs();
    @(negedge clk);
    exp_ready = '0;
    if (mdl_busy && (!mdl_ov || m_ready)) exp_ready[mdl_sel] = 1'b1;
    checks++;
    if (s_ready !== exp_ready) begin
      failures++;
      $display("FAIL s_ready: got %b expected %b at %0t", s_ready, exp_ready, $time);
    end
    checks++;
    if (busy !== mdl_busy) begin
      failures++;
      $display("FAIL busy: got %b expected %b at %0t", busy, mdl_busy, $time);
    end
    checks++;
    if (m_valid !== mdl_ov) begin
      failures++;
      $display("FAIL m_valid: got %b expected %b at %0t", m_valid, mdl_ov, $time);
    end
    if (mdl_ov) begin
      if (expq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL scoreboard: got beat expected none at %0t", $time);
      end else begin
        b = expq[0];
        checks++;
        if (m_data !== b.data || m_id !== b.id || m_last !== b.last) begin
          failures++;
          $display("FAIL beat: got data=%0h id=%0d last=%b expected data=%0h id=%0d last=%b at %0t",
                   m_data, m_id, m_last, b.data, b.id, b.last, $time);
        end
        if (m_ready) begin
          void'(expq.pop_front());
          beats_out++;
        end
      end
    end

    hs   = 0;
    ov_n = mdl_ov && !m_ready;
    if (mdl_busy) begin
      hs = valid_en[mdl_sel] && (chq[mdl_sel].size() > 0) && (!mdl_ov || m_ready);
      if (hs) ov_n = 1;
    end

    @(posedge clk);
    #1;
    if (!mdl_busy) begin
      // Arbitration uses the inputs that were present at this edge.
      int len;
      len = eff_len();
      for (int k = 1; k <= NUM; k++) begin
        int c;
        c = (mdl_ptr + k) % NUM;
        if (eligible(c, len)) begin
          int n;
          n        = (chq[c].size() < len) ? chq[c].size() : len;
          mdl_busy = 1;
          mdl_sel  = c;
          mdl_rem  = n;
          for (int j = 0; j < n; j++) begin
            b.data = chq[c][j];
            b.id   = IW'(c);
            b.last = (j == n - 1);
            expq.push_back(b);
          end
          break;
        end
      end
    end else if (hs) begin
      void'(chq[mdl_sel].pop_front());
      mdl_rem--;
      if (mdl_rem == 0) begin
        mdl_busy = 0;
        mdl_ptr  = mdl_sel;
      end
    end
    mdl_ov = ov_n;
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic push(int c, int n);
    for (int i = 0; i < n; i++) chq[c].push_back(DW'($urandom));
  endtask

  // Flush everything out and return to idle, within a cycle budget.
  task automatic drain();
    int  guard;
    bit  empty;
    flush    = '1;
    valid_en = '1;
    m_ready  = 1'b1;
    guard    = 0;
    empty    = 0;
    while (!empty && guard < 3000) begin
      cycle();
      guard++;
      empty = !mdl_busy && !mdl_ov;
      for (int i = 0; i < NUM; i++) if (chq[i].size() != 0) empty = 0;
    end
    checks++;
    if (!empty) begin
      failures++;
      $display("FAIL drain_timeout: got pending data expected empty after %0d cycles", guard);
    end
    flush = '0;
  endtask

  task automatic check_zero_outputs(string tag);
    checks++;
    if (m_valid !== 1'b0 || m_data !== '0 || m_id !== '0 || m_last !== 1'b0 ||
        busy !== 1'b0 || s_ready !== '0) begin
      failures++;
      $display("FAIL %s: got valid=%b data=%0h id=%0d last=%b busy=%b ready=%b expected all zero",
               tag, m_valid, m_data, m_id, m_last, busy, s_ready);
    end
  endtask

  task automatic pulse_reset();
    #2;
    reset = 1'b1;
    #1;
    check_zero_outputs("async_reset");
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    m_ready  = 1'b0;
    valid_en = '0;
    flush    = '0;
    plen     = 8'd4;
    model_reset();
    drive_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero_outputs("reset_state");
    @(posedge clk);
    #1;
    reset = 1'b0;
    run(2);
    $display("test_reset done checks=%0d", checks);
  endtask

  task automatic test_two_channel();
    valid_en = '1;
    m_ready  = 1'b1;
    plen     = 8'd4;
    push(0, 4);
    push(2, 4);
    run(16);
    drain();
    $display("test_two_channel done checks=%0d", checks);
  endtask

  task automatic test_round_robin();
    pulse_reset();
    valid_en = '1;
    m_ready  = 1'b1;
    plen     = 8'd2;
    for (int c = 0; c < NUM; c++) push(c, 8);
    run(60);
    drain();
    $display("test_round_robin done checks=%0d", checks);
  endtask

  task automatic test_flush();
    valid_en = '1;
    m_ready  = 1'b1;
    plen     = 8'd8;
    push(1, 3);
    run(15);
    checks++;
    if (busy !== 1'b0 || m_valid !== 1'b0) begin
      failures++;
      $display("FAIL short_no_grant: got busy=%b valid=%b expected 0 0", busy, m_valid);
    end
    flush[1] = 1'b1;
    run(10);
    flush = '0;
    drain();
    $display("test_flush done checks=%0d", checks);
  endtask

  task automatic test_stall();
    int start;
    int guard;
    valid_en = '1;
    m_ready  = 1'b1;
    plen     = 8'd4;
    push(3, 4);
    start = beats_out;
    guard = 0;
    while (beats_out < start + 2 && guard < 50) begin
      cycle();
      guard++;
    end
    checks++;
    if (beats_out < start + 2) begin
      failures++;
      $display("FAIL stall_setup: got %0d beats expected 2", beats_out - start);
    end
    m_ready = 1'b0;
    run(5);
    m_ready = 1'b1;
    drain();
    checks++;
    if (beats_out - start !== 4) begin
      failures++;
      $display("FAIL stall_beats: got %0d expected 4", beats_out - start);
    end
    $display("test_stall done checks=%0d", checks);
  endtask

  task automatic test_midburst();
    int guard;
    valid_en = '1;
    m_ready  = 1'b1;
    plen     = 8'd4;
    push(0, 4);
    guard = 0;
    while (!(mdl_busy && mdl_sel == 0 && mdl_rem == 3) && guard < 50) begin
      cycle();
      guard++;
    end
    push(1, 4);
    push(2, 4);
    valid_en[0] = 1'b0;
    plen        = 8'd1;
    run(3);
    valid_en = '1;
    drain();
    $display("test_midburst done checks=%0d", checks);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        int c;
        c = $urandom_range(0, NUM - 1);
        if (chq[c].size() < 20) push(c, $urandom_range(1, 4));
      end
      if ($urandom_range(0, 15) == 0) plen = LW'($urandom_range(0, 5));
      flush    = ($urandom_range(0, 7) == 0) ? NUM'($urandom) : '0;
      valid_en = ($urandom_range(0, 3) == 0) ? NUM'($urandom) : '1;
      m_ready  = ($urandom_range(0, 3) != 0);
      cycle();
    end
    drain();
    $display("test_random done checks=%0d", checks);
  endtask

  task automatic test_reset_mid();
    int guard;
    bit seen;
    valid_en = '1;
    m_ready  = 1'b1;
    plen     = 8'd4;
    push(1, 8);
    guard = 0;
    while (!(mdl_busy && mdl_sel == 1 && mdl_rem == 2) && guard < 50) begin
      cycle();
      guard++;
    end
    pulse_reset();
    push(0, 4);
    guard = 0;
    seen  = 0;
    while (!seen && guard < 10) begin
      cycle();
      guard++;
      seen = (m_valid === 1'b1);
    end
    checks++;
    if (!seen || m_id !== '0) begin
      failures++;
      $display("FAIL reset_priority: got valid=%b id=%0d expected 1 0", seen, m_id);
    end
    drain();
    $display("test_reset_mid done checks=%0d", checks);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    beats_out = 0;
    test_reset();
    test_two_channel();
    test_round_robin();
    test_flush();
    test_stall();
    test_midburst();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
